// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 raster constants for the VGA timing generator.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned FRAME_W = 16;

  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned HS_START = 656;
  localparam int unsigned HS_END   = 751;
  localparam int unsigned VS_START = 490;
  localparam int unsigned VS_END   = 491;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic vde;
  } sync_t;

  localparam sync_t SYNC_IDLE = '0;

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Clock-enabled shift register that delays the raw sync/blank flags; DEPTH=0 is a plain wire.
module sync_delay_line
  import vga_timing_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic  pixel_clk,
  input  logic  flush,
  input  logic  hold,
  input  sync_t d,
  output sync_t q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = pixel_clk ^ flush ^ hold;
    assign q = d;
  end else begin : g_pipe
    sync_t stage [DEPTH];

    // Flush takes priority over hold so a reset always empties the line
    always_ff @(posedge pixel_clk) begin
      if (flush) begin
        for (int i = 0; i < int'(DEPTH); i++) stage[i] <= SYNC_IDLE;
      end else if (!hold) begin
        stage[0] <= d;
        for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: h/v counters lead the delayed syncs by PIPE_LAT cycles.
// Optional line-compare interrupt is built when VTG_LINE_IRQ_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIPE_LAT = 2,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic               pixel_clk,
  input  logic               arstn,
  input  logic               en,
  input  logic [COORD_W-1:0] line_cmp,
  output logic [COORD_W-1:0] drawX,
  output logic [COORD_W-1:0] drawY,
  output logic               req_vde,
  output logic               hsync,
  output logic               vsync,
  output logic               vde,
  output logic               sof,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               line_irq
);

  localparam int unsigned LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_FIRST    = H_ACTIVE + H_FP;
  localparam int unsigned HS_LAST     = HS_FIRST + H_SYNC - 1;
  localparam int unsigned VS_FIRST    = V_ACTIVE + V_FP;
  localparam int unsigned VS_LAST     = VS_FIRST + V_SYNC - 1;

  coord_t hc;
  coord_t vc;
  logic   line_end;
  logic   frame_end;
  sync_t  raw;
  sync_t  dly;

  assign line_end  = (hc == coord_t'(LINE_LEN - 1));
  assign frame_end = line_end && (vc == coord_t'(FRAME_LINES - 1));

  // Raster counters and completed-frame count
  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      hc        <= '0;
      vc        <= '0;
      frame_cnt <= '0;
    end else if (en) begin
      hc <= line_end ? '0 : hc + coord_t'(1);
      if (line_end) vc <= frame_end ? '0 : vc + coord_t'(1);
      if (frame_end) frame_cnt <= frame_cnt + FRAME_W'(1);
    end
  end

  always_comb begin
    raw     = SYNC_IDLE;
    raw.hs  = (hc >= coord_t'(HS_FIRST)) && (hc <= coord_t'(HS_LAST));
    raw.vs  = (vc >= coord_t'(VS_FIRST)) && (vc <= coord_t'(VS_LAST));
    raw.vde = (hc < coord_t'(H_ACTIVE)) && (vc < coord_t'(V_ACTIVE));
  end

  sync_delay_line #(
    .DEPTH (PIPE_LAT)
  ) u_sync_delay_line (
    .pixel_clk (pixel_clk),
    .flush     (!arstn),
    .hold      (!en),
    .d         (raw),
    .q         (dly)
  );

  assign drawX   = hc;
  assign drawY   = vc;
  assign req_vde = raw.vde;
  assign hsync   = dly.hs ^ ~SYNC_POL;
  assign vsync   = dly.vs ^ ~SYNC_POL;
  assign vde     = dly.vde;
  assign sof     = (hc == '0) && (vc == '0) && en;

`ifdef VTG_LINE_IRQ_EN
  // vc never reaches FRAME_LINES, so out-of-range compare values never fire
  always_ff @(posedge pixel_clk) begin
    if (!arstn) line_irq <= 1'b0;
    else if (en) line_irq <= line_end && (vc == line_cmp);
  end
`else
  logic unused_line_cmp;
  assign unused_line_cmp = ^line_cmp;
  assign line_irq        = 1'b0;
`endif

endmodule
